// File: rtl/ysyx_25040111_cache_axi_rd.sv
// Cache refill engine: turns one refill request into a single AXI4 INCR read
// burst and forwards every returned beat to the cache as a one-cycle pulse.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   S_IDLE   | waiting for rstart; request fields captured on accept
//   S_AR_REQ | arvalid high, address/length held until AR handshake
//   S_R_DATA | rready high, one beat accepted per rvalid cycle
module ysyx_25040111_cache_axi_rd #(
  parameter int AXI_ID = 0,
  parameter int ID_W   = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rstart,
  input  logic [31:0]     raddr,
  input  logic [7:0]      rlen,
  output logic            rok,
  output logic [31:0]     rdata,
  output logic            rerr,
  output logic            busy,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [ID_W-1:0] arid,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  input  logic            rvalid,
  output logic            rready,
  input  logic [31:0]     axi_rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic [ID_W-1:0] rid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_AR_REQ = 2'd1,
    S_R_DATA = 2'd2
  } state_t;

  localparam logic [ID_W-1:0] ID_VAL = ID_W'(AXI_ID);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] beat_cnt;
  logic       ar_hs;
  logic       r_hs;
  logic       last_beat;

  assign ar_hs     = arvalid & arready;
  assign r_hs      = rvalid & rready;
  assign last_beat = (beat_cnt == arlen);

  assign arid    = ID_VAL;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: the beat counter alone ends the burst, rlast is only checked
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (rstart)            state_nxt = S_AR_REQ;
      S_AR_REQ: if (ar_hs)             state_nxt = S_R_DATA;
      S_R_DATA: if (r_hs && last_beat) state_nxt = S_IDLE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from state
  always_comb begin
    arvalid = 1'b0;
    rready  = 1'b0;
    busy    = 1'b0;
    case (state)
      S_AR_REQ: begin
        arvalid = 1'b1;
        busy    = 1'b1;
      end
      S_R_DATA: begin
        rready = 1'b1;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  // Request capture, beat counting and registered beat delivery
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      araddr   <= 32'd0;
      arlen    <= 8'd0;
      beat_cnt <= 8'd0;
      rdata    <= 32'd0;
      rok      <= 1'b0;
      rerr     <= 1'b0;
    end else begin
      rok  <= r_hs;
      rerr <= r_hs & ((rresp != 2'b00) | (rid != ID_VAL) | (rlast != last_beat));
      if (r_hs)
        rdata <= axi_rdata;
      if ((state == S_IDLE) && rstart) begin
        araddr <= {raddr[31:2], 2'b00};
        arlen  <= rlen;
      end
      if (ar_hs)
        beat_cnt <= 8'd0;
      else if (r_hs)
        beat_cnt <= beat_cnt + 8'd1;
    end
  end

endmodule

// File: doc/ysyx_25040111_cache_axi_rd.md
Name: ysyx_25040111_cache_axi_rd

Overview:
- Memory-side refill engine for the L1 cache.
- Accepts a refill request (start pulse, word-aligned address, beat count) and issues one AXI4 INCR read burst.
- Returns each received beat as a one-cycle data-valid pulse plus 32-bit word on the cache refill interface.
- Sits between the cache and the AXI interconnect; one outstanding burst at a time.

Parameters:
- AXI_ID, 0, ARID driven on every request and RID value expected on every beat.
- ID_W, 4, width of ARID/RID.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rstart  in  1  refill request pulse from cache; sampled only in IDLE.
- raddr  in  32  refill start address; bits [1:0] forced to 0 on capture.
- rlen  in  8  beats minus one (AXI arlen encoding).
- rok  out  1  one-cycle pulse: rdata valid for one beat.
- rdata  out  32  registered beat data.
- rerr  out  1  one-cycle pulse coincident with rok for a faulty beat.
- busy  out  1  high whenever state != IDLE.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- araddr  out  32  AXI AR address.
- arid  out  ID_W  AXI AR id (= AXI_ID).
- arlen  out  8  AXI AR burst length.
- arsize  out  3  constant 3'b010.
- arburst  out  2  constant 2'b01 (INCR).
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.
- axi_rdata  in  32  AXI R data.
- rresp  in  2  AXI R response.
- rlast  in  1  AXI R last.
- rid  in  ID_W  AXI R id.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - arvalid=0, rready=0, rok=0, rerr=0, busy=0.
  - rdata=0, araddr=0, arlen=0, beat counter=0.
  - Effective immediately, mid-burst included; in-flight AXI traffic is abandoned (interconnect is reset together).
- IDLE:
  - rstart=1 at posedge: capture araddr={raddr[31:2],2'b00} and arlen=rlen, then go AR_REQ.
  - Otherwise hold.
- AR_REQ:
  - arvalid=1; araddr/arlen/arid held stable until handshake.
  - arvalid & arready at posedge: go R_DATA, beat counter=0.
  - arvalid never drops before the handshake.
- R_DATA:
  - rready=1 combinationally from state.
  - On each rvalid & rready posedge:
    - Next cycle, rdata=axi_rdata and rok=1 (latency: 1 cycle after handshake).
    - Counter increments.
  - On the handshake where counter==arlen: go IDLE (busy drops the next cycle, same cycle as the final rok).
- Termination is by counter only. rlast does not end the burst; a mismatch is flagged instead.
- rerr=1 with the beat's rok when any of these hold:
  - rresp != 2'b00;
  - rid != AXI_ID;
  - rlast != (counter==arlen).
- Beats are always forwarded, including faulty ones.
- rok is never asserted in consecutive cycles for the same beat; back-to-back beats give back-to-back rok pulses.
- rstart outside IDLE is ignored, including in the cycle of the final R handshake. No queuing.
- rstart in IDLE is accepted on the cycle after busy falls.
- rlen=0: single-beat burst; that beat must carry rlast=1.
- Counter is 8 bits; maximum burst is 256 beats (rlen=255), with no wrap during a legal burst.
- araddr is not incremented internally; the slave handles INCR.
- rvalid outside R_DATA: ignored (rready=0).

Test Plan:
- Single beat: rstart, raddr=0x8000_0006, rlen=0; arready after 2 cycles; rvalid with 0xDEADBEEF, rlast=1, rresp=0.
  - -> araddr=0x8000_0004, arlen=0, arvalid held 3 cycles.
  - -> one rok with rdata=0xDEADBEEF, rerr=0, busy low afterwards.
- 4-beat burst: rlen=3, slave returns 0x11,0x22,0x33,0x44 back-to-back, rlast on the 4th.
  - -> 4 consecutive rok pulses in order, then IDLE; rstart mid-burst has no effect (single AR seen).
- Stalled R: rvalid toggling 1,0,0,1,1,0,1 over 4 beats.
  - -> rok pulses exactly 1 cycle after each handshake, total 4.
- Errors: 2-beat burst with beat 0 rresp=2'b10 and beat 1 rlast=0.
  - -> rerr on both rok pulses, burst still ends after 2 beats.
- Reset mid-burst: assert reset low between beats 1 and 2 of a 4-beat burst.
  - -> rready, arvalid, busy, rok drop asynchronously.
  - -> after release, a new rstart issues a fresh AR with the new address.
- Wrong ID: rid=AXI_ID+1 on a single beat -> rok=1, rerr=1.
